// File: rtl/seq_pattern_gen_pkg.sv
// seq_gen_pkg: shared encodings for the serial pattern generator.
// Holds the FSM state type and the loop-mode constants used by
// seq_pattern_gen and its testbench.
package seq_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_LOOP    = 1'b1;

endpackage

// File: rtl/seq_pattern_gen_bit_timer.sv
// seq_bit_timer: counts BIT_CYCLES clocks per serial bit.
// bit_tick is high on the last clock of each bit while enabled.
// clr has priority over en and returns the count to zero.
module seq_bit_timer #(
  parameter int BIT_CYCLES = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int                CNT_W    = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_bit_cnt;

  // Per-bit clock counter with explicit wrap at the last clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (clr) begin
      r_bit_cnt <= '0;
    end else if (en) begin
      if (r_bit_cnt == CNT_LAST) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  assign bit_tick = en && (r_bit_cnt == CNT_LAST);

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: replays a PAT_LEN-bit pattern on sig_out, bit 0 first,
// each bit held BIT_CYCLES clocks, one-shot or looping, with a
// double-buffered pattern register.
// Optional build macro SEQ_PATTERN_GEN_PARITY_EN appends one even-parity
// bit (XOR of the active pattern) after the last pattern bit.
// Control: start is a one-cycle request taken only in IDLE; stop is taken
// only in RUN and always wins over frame completion. frame_done is
// combinational so that a stop on the last clock can suppress it.
// dbg_state exposes the FSM state for observation.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int   PAT_LEN    = 8,
  parameter int   BIT_CYCLES = 50,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_mode,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_data,
  output logic               sig_out,
  output logic               busy,
  output logic               frame_done,
  output state_t             dbg_state
);

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  localparam int NBITS = PAT_LEN + 1;
`else
  localparam int NBITS = PAT_LEN;
`endif
  localparam int               IDX_W    = $clog2(PAT_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PAT_LEN-1:0] r_shadow;
  logic [PAT_LEN-1:0] r_active;
  logic               r_pending;
  logic               r_loop;
  logic [IDX_W-1:0]   r_idx;
  logic               r_sig_out;

  logic               w_loop_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_sig_nxt;
  logic               w_frame_start;
  logic               w_frame_done;
  logic               w_timer_clr;
  logic               w_bit_tick;
  logic [PAT_LEN-1:0] w_pat_new;

  // Bit i of the transmitted frame (pattern bits, then optional parity).
  function automatic logic frame_bit(input logic [PAT_LEN-1:0] pat,
                                     input logic [IDX_W-1:0]   i);
    logic [NBITS-1:0] fr;
    logic [NBITS-1:0] sh;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    fr = {^pat, pat};
`else
    fr = pat;
`endif
    sh = fr >> i;
    return sh[0];
  endfunction

  // Pattern that a frame starting this cycle uses: a same-cycle load wins,
  // else a pending shadow value, else the current active pattern.
  assign w_pat_new = pat_load  ? pat_data :
                     r_pending ? r_shadow : r_active;

  seq_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_timer_clr),
    .en       (r_state == ST_RUN),
    .bit_tick (w_bit_tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next output bit, bit index and frame boundary decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_loop_nxt    = r_loop;
    w_idx_nxt     = r_idx;
    w_sig_nxt     = r_sig_out;
    w_frame_start = 1'b0;
    w_frame_done  = 1'b0;
    w_timer_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sig_nxt   = IDLE_LEVEL;
        w_timer_clr = 1'b1;
        if (start) begin
          w_state_nxt   = ST_RUN;
          w_loop_nxt    = loop_mode;
          w_frame_start = 1'b1;
          w_idx_nxt     = '0;
          w_sig_nxt     = w_pat_new[0];
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_sig_nxt   = IDLE_LEVEL;
          w_timer_clr = 1'b1;
        end else if (w_bit_tick) begin
          if (r_idx == IDX_LAST) begin
            w_frame_done = 1'b1;
            if (r_loop == MODE_LOOP) begin
              w_frame_start = 1'b1;
              w_idx_nxt     = '0;
              w_sig_nxt     = w_pat_new[0];
            end else begin
              w_state_nxt = ST_IDLE;
              w_sig_nxt   = IDLE_LEVEL;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            w_sig_nxt = frame_bit(r_active, r_idx + IDX_W'(1));
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sig_nxt   = IDLE_LEVEL;
      end
    endcase
  end

  // Datapath: output bit, index, loop flag and the pattern double buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig_out <= IDLE_LEVEL;
      r_idx     <= '0;
      r_loop    <= MODE_ONESHOT;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_sig_out <= w_sig_nxt;
      r_idx     <= w_idx_nxt;
      r_loop    <= w_loop_nxt;
      if (w_frame_start) begin
        r_active  <= w_pat_new;
        r_pending <= 1'b0;
        if (pat_load) begin
          r_shadow <= pat_data;
        end
      end else if (pat_load) begin
        r_shadow  <= pat_data;
        r_pending <= 1'b1;
      end
    end
  end

  assign sig_out    = r_sig_out;
  assign busy       = (r_state == ST_RUN);
  assign frame_done = w_frame_done && rst_n;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: scoreboard bench for seq_pattern_gen (PAT_LEN=8,
// BIT_CYCLES=4). The reference model expands each frame into a per-clock
// waveform queue from the pattern; a monitor compares every cycle.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  localparam int   PAT_LEN    = 8;
  localparam int   BIT_CYCLES = 4;
  localparam logic IDLE_LEVEL = 1'b0;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               loop_mode;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_data;
  logic               sig_out;
  logic               busy;
  logic               frame_done;
  state_t             dbg_state;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_LEN    (PAT_LEN),
    .BIT_CYCLES (BIT_CYCLES),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop_mode  (loop_mode),
    .pat_load   (pat_load),
    .pat_data   (pat_data),
    .sig_out    (sig_out),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // expected per cycle: {busy, sig_out, frame_done, running}
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         exp_done_cnt = 0;
  int         act_done_cnt = 0;

  // ---------------- reference model ----------------
  bit                 m_run = 1'b0;
  bit                 m_loop = 1'b0;
  bit                 m_pending = 1'b0;
  logic [PAT_LEN-1:0] m_shadow = '0;
  logic [PAT_LEN-1:0] m_active = '0;
  bit                 wave_q[$];

  task automatic begin_frame(input logic ld, input logic [PAT_LEN-1:0] d);
    if (ld) begin
      m_active = d;
      m_shadow = d;
    end else if (m_pending) begin
      m_active = m_shadow;
    end
    m_pending = 1'b0;
    wave_q.delete();
    for (int b = 0; b < PAT_LEN; b++)
      for (int c = 0; c < BIT_CYCLES; c++) wave_q.push_back(m_active[b]);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    for (int c = 0; c < BIT_CYCLES; c++) wave_q.push_back(^m_active);
`endif
  endtask

  // Expected outputs for the current cycle, then the effect of the next edge.
  task automatic model_step();
    logic e_sig;
    logic e_done;
    bit   started;
    e_sig   = m_run ? wave_q[0] : IDLE_LEVEL;
    e_done  = rst_n && m_run && !stop && (wave_q.size() == 1);
    started = 1'b0;
    exp_q.push_back({m_run, e_sig, e_done, m_run});
    if (e_done) exp_done_cnt++;
    if (!rst_n) begin
      m_run = 0; m_loop = 0; m_pending = 0;
      m_shadow = '0; m_active = '0;
      wave_q.delete();
    end else begin
      if (m_run) begin
        if (stop) begin
          m_run = 1'b0;
          wave_q.delete();
        end else begin
          void'(wave_q.pop_front());
          if (wave_q.size() == 0) begin
            if (m_loop) begin
              begin_frame(pat_load, pat_data);
              started = 1'b1;
            end else begin
              m_run = 1'b0;
            end
          end
        end
      end else if (start) begin
        m_run  = 1'b1;
        m_loop = loop_mode;
        begin_frame(pat_load, pat_data);
        started = 1'b1;
      end
      if (!started && pat_load) begin
        m_shadow  = pat_data;
        m_pending = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic s, input logic p,
                       input logic l, input logic ld,
                       input logic [PAT_LEN-1:0] d);
    rst_n     = r;
    start     = s;
    stop      = p;
    loop_mode = l;
    pat_load  = ld;
    pat_data  = d;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3:0] exp;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) act_done_cnt++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {busy, sig_out, frame_done, (dbg_state == ST_RUN)};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL outputs cycle=%0d {busy,sig,done,run} actual=%b required=%b",
                   cyc, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    loop_mode = 1'b0; pat_load = 1'b0; pat_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state held for a cycle
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // one-shot frame of 8'b1011_0010
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b1011_0010);
    drive(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 1'b0, '0);
    idle(36);

    // loop 8'hA5, reload 8'h0F in the middle of frame 2
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    drive(1'b1, 1'b1, 1'b0, MODE_LOOP, 1'b0, '0);
    idle(47);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F);
    idle(70);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(3);

    // stop on clock 13, then stop on the last clock of a frame
    drive(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 1'b0, '0);
    idle(12);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, MODE_LOOP, 1'b0, '0);
    idle(31);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(3);

    // reset mid-frame, then replay of the cleared pattern
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    drive(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 1'b0, '0);
    idle(10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 1'b0, '0);
    idle(35);

    // start during RUN ignored; start+stop together in IDLE begins a frame
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    drive(1'b1, 1'b1, 1'b0, MODE_LOOP, 1'b0, '0);
    idle(5);
    drive(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 1'b0, '0);
    idle(40);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);
    drive(1'b1, 1'b1, 1'b1, MODE_ONESHOT, 1'b0, '0);
    idle(34);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 14) == 0),
            PAT_LEN'($urandom_range(0, 255)));
    end
    idle(2);

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    checks++;
    if (act_done_cnt != exp_done_cnt) begin
      failures++;
      $display("FAIL frame_count actual=%0d required=%0d", act_done_cnt, exp_done_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Parametrised serial waveform generator: replays a programmable PAT_LEN-bit pattern on one output, each bit held BIT_CYCLES clocks.
- Supports one-shot and continuous-loop modes, start/stop control, double-buffered pattern reload and frame-done signalling.
- Drives indicator LEDs and serial test stimuli; successor to the fixed-pattern, fixed-period signal generator.

Parameters:
- PAT_LEN, 8, number of bits per frame; must be at least 2.
- BIT_CYCLES, 50, clocks per bit; must be at least 2 (50 clocks = 1 us at 50 MHz).
- IDLE_LEVEL, 1'b0, sig_out level whenever the block is not running.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- stop  in  1  abort request; honoured in RUN.
- loop_mode  in  1  0 = one-shot, 1 = repeat frames; sampled with start.
- pat_load  in  1  write strobe for pat_data.
- pat_data  in  PAT_LEN  pattern; bit 0 is sent first.
- sig_out  out  1  registered serial output.
- busy  out  1  high while in RUN.
- frame_done  out  1  one-cycle pulse in the last clock of every completed frame.

Behaviour:
- Synchronous reset (rst_n low at a clk edge):
  - state = IDLE; sig_out = IDLE_LEVEL; busy = 0; frame_done = 0.
  - Shadow and active pattern registers = 0; pending flag = 0; counters = 0.
- Pattern double buffer:
  - pat_load writes the shadow register and sets pending.
  - At each frame start the active register takes the shadow value if pending, then pending clears.
  - pat_load during RUN never disturbs the frame in progress.
  - pat_load in the same cycle as a frame start: the new value is used for that frame.
- Counters:
  - bit_cnt: width $clog2(BIT_CYCLES), range 0..BIT_CYCLES-1.
  - idx: width $clog2(PAT_LEN+1); holds the current bit index.
  - Both wrap to 0 explicitly. No arithmetic overflow is permitted.
- FSM, two states:
  - IDLE: start=1 at edge N -> RUN. Latch loop_mode. Load active pattern. bit_cnt = 0, idx = 0. From the cycle after edge N: sig_out = pattern[0], busy = 1. Latency start -> first bit = 1 clock.
  - RUN: bit_cnt increments each clock.
    - At bit_cnt == BIT_CYCLES-1: bit_cnt -> 0, idx increments, sig_out = pattern[idx+1].
    - Last clock of the last bit (idx == PAT_LEN-1, bit_cnt == BIT_CYCLES-1): frame_done = 1 for that cycle.
    - One-shot: next cycle state = IDLE, sig_out = IDLE_LEVEL, busy = 0.
    - Loop: next cycle starts bit 0 of a new frame with no gap. The pattern reload rule applies. The frame period is exactly PAT_LEN*BIT_CYCLES clocks.
- stop in RUN: next cycle state = IDLE, sig_out = IDLE_LEVEL, busy = 0.
  - No frame_done, even if stop coincides with the last clock of a frame (stop wins).
- start while in RUN is ignored; it is not queued.
- start and stop together in IDLE: start is honoured; stop is ignored in IDLE.
- Reset mid-frame: immediate return to reset values on that edge. No frame_done.

Optional Feature:
- Macro: SEQ_PATTERN_GEN_PARITY_EN.
- Defined: one even-parity bit (XOR of the active pattern) is appended after bit PAT_LEN-1 and held BIT_CYCLES clocks. The frame becomes (PAT_LEN+1)*BIT_CYCLES clocks, and frame_done moves to the last clock of the parity bit.
- Undefined: no parity bit; behaviour exactly as above.

Decomposition:
- Package seq_gen_pkg:
  - state encoding constants ST_IDLE and ST_RUN.
  - mode constants MODE_ONESHOT = 0 and MODE_LOOP = 1.
- One natural sub-module, seq_bit_timer:
  - parametrised by BIT_CYCLES.
  - inputs clk, rst_n, clr, en; output bit_tick, high on the last clock of each bit.
  - The top level owns the FSM, pattern registers, idx and output register.

Test Plan (PAT_LEN=8, BIT_CYCLES=4 unless stated):
1. Load 8'b1011_0010, start with loop_mode=0 -> sig_out reads 0,1,0,0,1,1,0,1, each held 4 clocks starting 1 clock after start. frame_done on clock 32. busy falls and sig_out = 0 on clock 33.
2. Loop mode, pattern 8'hA5 -> continuous 32-clock period with no gap. frame_done every 32 clocks. Load 8'h0F mid-frame 2 -> frame 2 unchanged; frame 3 outputs 8'h0F.
3. stop on clock 13 of a frame -> sig_out = IDLE_LEVEL and busy = 0 on the next clock, no frame_done. stop on the last clock of a frame -> no frame_done.
4. rst_n low for 1 cycle mid-frame -> all outputs at reset values after that edge. A subsequent start replays pattern 0, since the pattern registers were cleared.
5. start pulsed during RUN -> ignored; the frame count is unchanged. start and stop together in IDLE -> frame begins.
6. With SEQ_PATTERN_GEN_PARITY_EN, pattern 8'b0000_0111 -> 9th bit = 1. Frame = 36 clocks; frame_done on clock 36.
